instr_mem_prog: RTL and testbench
=================================

Name: instr_mem_prog

Overview:
- Parametrised, programmable instruction memory: the successor to the fixed 8-bit, 16-entry reset-loaded instruction ROM.
- After reset, a boot sequencer writes a default program image one word per cycle; the memory then serves registered fetches to the core.
- A valid/ready programming port lets the testbench or loader overwrite any word at run time.
- Sits between the PC register and the decode stage of the single-cycle and multi-cycle cores.

Parameters:
- DATA_W, 8, instruction word width in bits.
- ADDR_W, 8, width of the PC/address inputs.
- DEPTH, 16, number of implemented words; legal range 6..2^ADDR_W.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- PC  input  ADDR_W  fetch address.
- Fetch_Req  input  1  fetch request for PC, sampled at the clock edge.
- Instruction_Code  output  DATA_W  registered fetch data.
- Fetch_Valid  output  1  Instruction_Code is valid this cycle.
- Addr_Err  output  1  last fetch address was >= DEPTH.
- Prog_Valid  input  1  programming write request.
- Prog_Ready  output  1  programming write accepted when high together with Prog_Valid.
- Prog_Addr  input  ADDR_W  programming write address.
- Prog_Data  input  DATA_W  programming write data.
- Busy  output  1  boot sequence in progress.

Behaviour:
- Reset low, asynchronous: state=BOOT, boot counter=0, Instruction_Code=0, Fetch_Valid=0, Addr_Err=0, Prog_Ready=0, Busy=1. Memory array contents are not reset directly.
- Default image, indexes 0..5: 8'h2B, 8'h6A, 8'h63, 8'hC1, 8'h14, 8'h55. All other indexes are 0. The image is zero-extended or truncated to DATA_W.
- BOOT state:
  - Each cycle, writes image[cnt] to Mem[cnt] and increments cnt.
  - After writing index DEPTH-1 (DEPTH cycles after reset release), moves to RUN and Busy drops to 0 in that same edge.
  - During BOOT: Fetch_Req is ignored (Fetch_Valid stays 0) and Prog_Ready=0.
- RUN state:
  - Prog_Ready=1 combinationally.
  - A write occurs at the edge where Prog_Valid && Prog_Ready. Mem[Prog_Addr] <= Prog_Data if Prog_Addr < DEPTH; otherwise the write is dropped silently.
  - Fetch has 1-cycle latency. At the edge with Fetch_Req=1:
    - Instruction_Code <= Mem[PC] if PC < DEPTH, else 0.
    - Addr_Err <= (PC >= DEPTH).
    - Fetch_Valid <= 1.
  - At an edge with Fetch_Req=0: Fetch_Valid <= 0; Instruction_Code and Addr_Err hold.
- Simultaneous write and fetch to the same address in the same cycle returns the OLD data (read-before-write). The new data is visible to the next fetch.
- Reset asserted mid-BOOT or mid-RUN aborts immediately to the reset state. An interrupted programming write is not committed. The boot sequence restarts from index 0 and the default image overwrites all programmed contents.
- PC and Prog_Addr wider than needed: only the comparison against DEPTH decides legality; there is no aliasing/wrap.
- States are encoded in 1 bit (BOOT=0, RUN=1). The boot counter is ceil(log2(DEPTH+1)) bits.

Test Plan:
- Boot: release Reset, hold Fetch_Req=1 throughout.
  - Busy=1 for exactly 16 cycles and Fetch_Valid=0 during that time.
  - Then fetch PC=0..5 on consecutive cycles; each word appears one cycle after its request, in order: 2B, 6A, 63, C1, 14, 55.
  - Fetch PC=6..15 returns 00.
- Programming: write Prog_Addr=3, Prog_Data=A7 with Prog_Valid=1 for one cycle.
  - Next fetch of PC=3 returns A7 with Addr_Err=0.
  - PC=2 still returns 63.
- Same-cycle collision: write Prog_Addr=1, Prog_Data=FF while fetching PC=1.
  - That fetch returns 6A.
  - The following fetch of PC=1 returns FF.
- Out of range: fetch PC=8'h20.
  - Instruction_Code=00, Addr_Err=1, Fetch_Valid=1.
  - A write to Prog_Addr=8'h20 changes no word; a readback of 0..15 is unchanged.
- Reset mid-operation:
  - After programming Mem[0]=99, pulse Reset low for a partial cycle. All outputs zero immediately (asynchronously) and Busy=1 immediately.
  - After the reboot completes, PC=0 returns 2B.
- Prog during BOOT: hold Prog_Valid=1 from reset release.
  - Prog_Ready stays 0 for 16 cycles.
  - The first accepted write occurs on the first RUN cycle.

Source files
------------

// File: rtl/instr_mem_prog_if.sv
// Fetch and programming signals between the core, the loader and instr_mem_prog.
// Modport master is used by the core/loader side and modport slave by the memory.
interface instr_mem_prog_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] PC;
    logic              Fetch_Req;
    logic [DATA_W-1:0] Instruction_Code;
    logic              Fetch_Valid;
    logic              Addr_Err;
    logic              Prog_Valid;
    logic              Prog_Ready;
    logic [ADDR_W-1:0] Prog_Addr;
    logic [DATA_W-1:0] Prog_Data;
    logic              Busy;

    modport master (
        output PC, Fetch_Req, Prog_Valid, Prog_Addr, Prog_Data,
        input  Instruction_Code, Fetch_Valid, Addr_Err, Prog_Ready, Busy
    );

    modport slave (
        input  PC, Fetch_Req, Prog_Valid, Prog_Addr, Prog_Data,
        output Instruction_Code, Fetch_Valid, Addr_Err, Prog_Ready, Busy
    );
endinterface

// File: rtl/instr_mem_prog.sv
// Programmable instruction memory: a boot sequencer loads a default image, then fetches are served.
// Latency: fetch data registered 1 cycle after Fetch_Req; boot takes DEPTH cycles after reset release.
// Backpressure: Prog_Ready low while booting, always high in RUN; fetches ignored while booting.
module instr_mem_prog #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    instr_mem_prog_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  boot_cnt, boot_cnt_nxt;
    logic              boot_we;
    logic              prog_rdy;
    logic              busy;
    logic              prog_addr_ok;
    logic              prog_we;
    logic              pc_ok;
    logic [DATA_W-1:0] instr_dat;
    logic              fetch_vld;
    logic              addr_err;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [DATA_W-1:0] image_word(input logic [CNT_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            CNT_W'(0): b = 8'h2B;
            CNT_W'(1): b = 8'h6A;
            CNT_W'(2): b = 8'h63;
            CNT_W'(3): b = 8'hC1;
            CNT_W'(4): b = 8'h14;
            CNT_W'(5): b = 8'h55;
            default:   b = 8'h00;
        endcase
        return DATA_W'(b);
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= BOOT;
            boot_cnt <= '0;
        end else begin
            state    <= state_nxt;
            boot_cnt <= boot_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        boot_cnt_nxt = boot_cnt;
        boot_we      = 1'b0;
        prog_rdy     = 1'b0;
        busy         = 1'b0;
        case (state)
            BOOT: begin
                busy         = 1'b1;
                boot_we      = 1'b1;
                boot_cnt_nxt = boot_cnt + 1'b1;
                if (boot_cnt == LAST_IDX) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                prog_rdy = 1'b1;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Legality is decided only by comparison against DEPTH; out-of-range addresses never alias.
    assign prog_addr_ok = {1'b0, bus.Prog_Addr} < DEPTH_X;
    assign pc_ok        = {1'b0, bus.PC} < DEPTH_X;
    assign prog_we      = bus.Prog_Valid && prog_rdy && prog_addr_ok;

    always_ff @(posedge Clk) begin
        if (boot_we) begin
            mem[boot_cnt[IDX_W-1:0]] <= image_word(boot_cnt);
        end else if (prog_we) begin
            mem[bus.Prog_Addr[IDX_W-1:0]] <= bus.Prog_Data;
        end
    end

    // Read samples mem before this edge's write lands, so a colliding fetch sees old data.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            instr_dat <= '0;
            fetch_vld <= 1'b0;
            addr_err  <= 1'b0;
        end else if (state == RUN && bus.Fetch_Req) begin
            fetch_vld <= 1'b1;
            addr_err  <= !pc_ok;
            instr_dat <= pc_ok ? mem[bus.PC[IDX_W-1:0]] : '0;
        end else begin
            fetch_vld <= 1'b0;
        end
    end

    assign bus.Instruction_Code = instr_dat;
    assign bus.Fetch_Valid      = fetch_vld;
    assign bus.Addr_Err         = addr_err;
    assign bus.Prog_Ready       = prog_rdy;
    assign bus.Busy             = busy;

endmodule

// File: tb/tb_instr_mem_prog.sv
// Randomised and directed stimulus for instr_mem_prog checked against a behavioural model.
module tb_instr_mem_prog;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    instr_mem_prog_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_mem_prog #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: memory contents, remaining boot cycles, and last registered fetch outputs.
    logic [7:0] m_mem [DEPTH];
    int         m_boot_left;
    logic       m_fv;
    logic       m_ae;
    logic [7:0] m_ic;

    function automatic logic [7:0] image_at(input int i);
        case (i)
            0: return 8'h2B;
            1: return 8'h6A;
            2: return 8'h63;
            3: return 8'hC1;
            4: return 8'h14;
            5: return 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot_left = DEPTH;
        m_fv = 1'b0;
        m_ae = 1'b0;
        m_ic = 8'h00;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = image_at(i);
    endtask

    // One clock cycle: drive, check combinational outputs, advance model at the edge, check registers.
    task automatic cyc(input logic fr, input logic [7:0] pc, input logic pv,
                       input logic [7:0] pa, input logic [7:0] pd);
        bus.Fetch_Req  = fr;
        bus.PC         = pc;
        bus.Prog_Valid = pv;
        bus.Prog_Addr  = pa;
        bus.Prog_Data  = pd;
        #1;
        chk("busy_pre", bus.Busy, m_boot_left > 0);
        chk("prog_ready", bus.Prog_Ready, m_boot_left == 0);
        @(posedge Clk);
        if (m_boot_left > 0) begin
            m_boot_left--;
            m_fv = 1'b0;
        end else begin
            if (fr) begin
                m_fv = 1'b1;
                m_ae = (pc >= DEPTH);
                m_ic = (pc < DEPTH) ? m_mem[pc[3:0]] : 8'h00;
            end else begin
                m_fv = 1'b0;
            end
            if (pv && pa < DEPTH) m_mem[pa[3:0]] = pd;
        end
        @(negedge Clk);
        chk("fetch_valid", bus.Fetch_Valid, m_fv);
        chk("instr_code", bus.Instruction_Code, m_ic);
        chk("addr_err", bus.Addr_Err, m_ae);
        chk("busy", bus.Busy, m_boot_left > 0);
    endtask

    task automatic pulse_reset();
        bus.Prog_Valid = 1'b1;
        bus.Prog_Addr  = 8'h00;
        bus.Prog_Data  = 8'h77;
        Reset = 1'b0;
        #1;
        chk("rst_instr_code", bus.Instruction_Code, 0);
        chk("rst_fetch_valid", bus.Fetch_Valid, 0);
        chk("rst_addr_err", bus.Addr_Err, 0);
        chk("rst_busy", bus.Busy, 1);
        chk("rst_prog_ready", bus.Prog_Ready, 0);
        model_reset();
        #1;
        Reset = 1'b1;
    endtask

    task automatic readback_all();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        Reset = 1'b0;
        bus.Fetch_Req  = 1'b0;
        bus.PC         = '0;
        bus.Prog_Valid = 1'b0;
        bus.Prog_Addr  = '0;
        bus.Prog_Data  = '0;
        model_reset();

        @(negedge Clk);
        #1;
        chk("init_instr_code", bus.Instruction_Code, 0);
        chk("init_fetch_valid", bus.Fetch_Valid, 0);
        chk("init_addr_err", bus.Addr_Err, 0);
        chk("init_busy", bus.Busy, 1);
        chk("init_prog_ready", bus.Prog_Ready, 0);
        Reset = 1'b1;

        // Boot with fetch and a pending write held; the write lands on the first RUN cycle.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom_range(0, 15)), 1'b1, 8'h07, 8'h3C);
        cyc(1'b1, 8'h00, 1'b1, 8'h07, 8'h3C);
        readback_all();

        cyc(1'b0, 8'h00, 1'b1, 8'h03, 8'hA7);
        cyc(1'b1, 8'h03, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 8'h02, 1'b0, 8'h00, 8'h00);

        // Same-cycle write and fetch of one address.
        cyc(1'b1, 8'h01, 1'b1, 8'h01, 8'hFF);
        cyc(1'b1, 8'h01, 1'b0, 8'h00, 8'h00);

        cyc(1'b1, 8'h20, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 8'h00, 1'b1, 8'h20, 8'h5A);
        readback_all();

        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)), 8'($urandom));
        end

        cyc(1'b0, 8'h00, 1'b1, 8'h00, 8'h99);
        cyc(1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
        pulse_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h00, 1'b1, 8'h00, 8'h99);
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom_range(0, 40)), 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
        readback_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
